// File: rtl/heap_array_engine.sv
// heap_array_engine: handle-based array allocator over a flat element store.
// Define ARRAY_INSERT_EN to add the INSERT op (elements shifted up one per cycle).
module heap_array_engine #(
    parameter int WIDTH   = 12,
    parameter int NARRAYS = 16,
    parameter int NAREA   = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [$clog2(NARRAYS)-1:0] cmd_array,
    input  logic [$clog2(NAREA+1)-1:0] cmd_index,
    input  logic [WIDTH-1:0]           cmd_data,
    output logic                       rsp_valid,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       rsp_error,
    output logic [$clog2(NARRAYS):0]   in_use
);
    localparam int AW = $clog2(NARRAYS);
    localparam int IW = $clog2(NAREA + 1);
    localparam int CW = AW + 1;
    localparam int MD = NARRAYS * NAREA;
    localparam int MW = (MD > 1) ? $clog2(MD) : 1;

    localparam logic [2:0] OP_ALLOC  = 3'd0;
    localparam logic [2:0] OP_FREE   = 3'd1;
    localparam logic [2:0] OP_WRITE  = 3'd2;
    localparam logic [2:0] OP_READ   = 3'd3;
    localparam logic [2:0] OP_SIZE   = 3'd4;
    localparam logic [2:0] OP_INSERT = 3'd5;

    localparam logic [CW-1:0] NARR_C    = CW'(NARRAYS);
    localparam logic [CW-1:0] CNT_ONE_C = CW'(1);
    localparam logic [IW-1:0] NAREA_C   = IW'(NAREA);
    localparam logic [IW-1:0] IDX_ONE_C = IW'(1);
    localparam logic [MW-1:0] AREA_C    = MW'(NAREA);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESP  = 2'd1
`ifdef ARRAY_INSERT_EN
        , ST_SHIFT = 2'd2
`endif
    } state_t;

    state_t              state_r;
    logic                cmd_ready_r;
    logic                rsp_valid_r;
    logic [WIDTH-1:0]    rsp_data_r;
    logic                rsp_error_r;
    logic [CW-1:0]       in_use_r;
    logic [CW-1:0]       next_r;
    logic [CW-1:0]       sp_r;
    logic [AW-1:0]       stack_r [NARRAYS];
    logic [NARRAYS-1:0]  alloc_r;
    logic [IW-1:0]       size_r [NARRAYS];
    logic [WIDTH-1:0]    mem_r [MD];

    logic                accept_s;
    logic                arr_ok_s;
    logic                idx_ok_s;
    logic                tgt_ok_s;
    logic [IW-1:0]       cur_size_s;
    logic [MW-1:0]       base_s;
    logic [MW-1:0]       addr_s;
    logic [CW-1:0]       sp_m1_s;
    logic [AW-1:0]       alloc_h_s;
    logic                err_s;
    logic [WIDTH-1:0]    res_s;
    logic                mem_we_s;
    logic [MW-1:0]       mem_wa_s;
    logic [WIDTH-1:0]    mem_wd_s;

`ifdef ARRAY_INSERT_EN
    logic [MW-1:0]       sh_base_r;
    logic [AW-1:0]       sh_arr_r;
    logic [IW-1:0]       sh_ptr_r;
    logic [IW-1:0]       sh_idx_r;
    logic [WIDTH-1:0]    sh_data_r;
    logic [MW-1:0]       sh_src_s;
`endif

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_error = rsp_error_r;
    assign in_use    = in_use_r;

    // Command decode: legality check and the response value of a single-cycle op.
    always_comb begin
        accept_s   = cmd_valid && cmd_ready_r;
        arr_ok_s   = (CW'(cmd_array) < NARR_C);
        idx_ok_s   = (cmd_index < NAREA_C);
        cur_size_s = size_r[cmd_array];
        tgt_ok_s   = arr_ok_s && alloc_r[cmd_array] && idx_ok_s;
        base_s     = MW'(cmd_array) * AREA_C;
        addr_s     = base_s + MW'(cmd_index);
        sp_m1_s    = sp_r - CNT_ONE_C;
        if (sp_r != '0) begin
            alloc_h_s = stack_r[sp_m1_s[AW-1:0]];
        end else begin
            alloc_h_s = next_r[AW-1:0];
        end
        err_s = 1'b1;
        res_s = '0;
        case (cmd_op)
            OP_ALLOC: begin
                err_s = (sp_r == '0) && (next_r == NARR_C);
                res_s = WIDTH'(alloc_h_s);
            end
            OP_FREE: begin
                err_s = !tgt_ok_s;
                res_s = WIDTH'(cmd_array);
            end
            OP_WRITE: begin
                err_s = !tgt_ok_s;
                res_s = cmd_data;
            end
            OP_READ: begin
                err_s = !tgt_ok_s;
                res_s = mem_r[addr_s];
            end
            OP_SIZE: begin
                err_s = !tgt_ok_s;
                res_s = WIDTH'(cur_size_s);
            end
`ifdef ARRAY_INSERT_EN
            OP_INSERT: begin
                err_s = !tgt_ok_s || (cur_size_s >= NAREA_C) || (cmd_index > cur_size_s);
                res_s = cmd_data;
            end
`endif
            default: begin
                err_s = 1'b1;
                res_s = '0;
            end
        endcase
    end

    // Element store write port: WRITE in IDLE, or one shift/insert step per SHIFT cycle.
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = addr_s;
        mem_wd_s = cmd_data;
`ifdef ARRAY_INSERT_EN
        sh_src_s = sh_base_r + MW'(sh_ptr_r) - MW'(1);
        if (state_r == ST_SHIFT) begin
            mem_we_s = 1'b1;
            mem_wa_s = sh_base_r + MW'(sh_ptr_r);
            if (sh_ptr_r == sh_idx_r) begin
                mem_wd_s = sh_data_r;
            end else begin
                mem_wd_s = mem_r[sh_src_s];
            end
        end else
`endif
        if ((state_r == ST_IDLE) && accept_s && !err_s && (cmd_op == OP_WRITE)) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Element memory is deliberately not reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[mem_wa_s] <= mem_wd_s;
        end
    end

    // Control FSM plus allocator bookkeeping; all outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_error_r <= 1'b0;
            in_use_r    <= '0;
            next_r      <= '0;
            sp_r        <= '0;
            alloc_r     <= '0;
            for (int i = 0; i < NARRAYS; i++) begin
                stack_r[i] <= '0;
                size_r[i]  <= '0;
            end
`ifdef ARRAY_INSERT_EN
            sh_base_r <= '0;
            sh_arr_r  <= '0;
            sh_ptr_r  <= '0;
            sh_idx_r  <= '0;
            sh_data_r <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rsp_valid_r <= 1'b0;
                    rsp_data_r  <= '0;
                    rsp_error_r <= 1'b0;
                    if (accept_s) begin
                        cmd_ready_r <= 1'b0;
                        if (err_s) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_error_r <= 1'b1;
                        end else begin
                            case (cmd_op)
                                OP_ALLOC: begin
                                    if (sp_r != '0) begin
                                        sp_r <= sp_m1_s;
                                    end else begin
                                        next_r <= next_r + CNT_ONE_C;
                                    end
                                    alloc_r[alloc_h_s] <= 1'b1;
                                    size_r[alloc_h_s]  <= '0;
                                    if (in_use_r != NARR_C) begin
                                        in_use_r <= in_use_r + CNT_ONE_C;
                                    end
                                end
                                OP_FREE: begin
                                    stack_r[sp_r[AW-1:0]] <= cmd_array;
                                    sp_r                  <= sp_r + CNT_ONE_C;
                                    alloc_r[cmd_array]    <= 1'b0;
                                    if (in_use_r != '0) begin
                                        in_use_r <= in_use_r - CNT_ONE_C;
                                    end
                                end
                                OP_WRITE: begin
                                    if (cmd_index >= cur_size_s) begin
                                        size_r[cmd_array] <= cmd_index + IDX_ONE_C;
                                    end
                                end
`ifdef ARRAY_INSERT_EN
                                OP_INSERT: begin
                                    sh_base_r <= base_s;
                                    sh_arr_r  <= cmd_array;
                                    sh_ptr_r  <= cur_size_s;
                                    sh_idx_r  <= cmd_index;
                                    sh_data_r <= cmd_data;
                                end
`endif
                                default: begin
                                end
                            endcase
`ifdef ARRAY_INSERT_EN
                            if (cmd_op == OP_INSERT) begin
                                state_r <= ST_SHIFT;
                            end else
`endif
                            begin
                                state_r     <= ST_RESP;
                                rsp_valid_r <= 1'b1;
                                rsp_data_r  <= res_s;
                            end
                        end
                    end
                end
`ifdef ARRAY_INSERT_EN
                // Pointer walks from size down to the insert slot; the slot itself takes the new data.
                ST_SHIFT: begin
                    if (sh_ptr_r == sh_idx_r) begin
                        size_r[sh_arr_r] <= size_r[sh_arr_r] + IDX_ONE_C;
                        state_r          <= ST_RESP;
                        rsp_valid_r      <= 1'b1;
                        rsp_data_r       <= sh_data_r;
                        rsp_error_r      <= 1'b0;
                    end else begin
                        sh_ptr_r <= sh_ptr_r - IDX_ONE_C;
                    end
                end
`endif
                ST_RESP: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_data_r  <= '0;
                    rsp_error_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_data_r  <= '0;
                    rsp_error_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_heap_array_engine.sv
// Self-checking bench for heap_array_engine: directed steps plus random commands
// compared against a behavioural model of allocator, sizes and contents.
module tb_heap_array_engine;
    localparam int WIDTH   = 12;
    localparam int NARRAYS = 16;
    localparam int NAREA   = 10;
    localparam int AW      = $clog2(NARRAYS);
    localparam int IW      = $clog2(NAREA + 1);

    logic             clock = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [AW-1:0]    cmd_array;
    logic [IW-1:0]    cmd_index;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_error;
    logic [AW:0]      in_use;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    heap_array_engine #(.WIDTH(WIDTH), .NARRAYS(NARRAYS), .NAREA(NAREA)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_array(cmd_array), .cmd_index(cmd_index), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error), .in_use(in_use)
    );

    // Reference model state
    bit m_alloc [NARRAYS];
    int m_size  [NARRAYS];
    int m_mem   [NARRAYS][NAREA];
    bit m_known [NARRAYS][NAREA];
    int m_freed [$];
    int m_next;
    int m_inuse;

    int obs_data;
    int obs_err;
    int obs_lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int a = 0; a < NARRAYS; a++) begin
            m_alloc[a] = 1'b0;
            m_size[a]  = 0;
            for (int e = 0; e < NAREA; e++) m_known[a][e] = 1'b0;
        end
        m_freed.delete();
        m_next  = 0;
        m_inuse = 0;
    endfunction

    function automatic void model_exec(input int op, input int arr, input int idx, input int data,
                                       output bit e_err, output int e_data, output bit e_known,
                                       output int e_lat);
        bit tgt;
        int h;
        e_err = 1'b0; e_data = 0; e_known = 1'b1; e_lat = 1;
        tgt = m_alloc[arr] && (idx < NAREA);
        case (op)
            0: begin
                if (m_freed.size() > 0) h = m_freed.pop_back();
                else if (m_next < NARRAYS) begin h = m_next; m_next++; end
                else e_err = 1'b1;
                if (!e_err) begin
                    m_alloc[h] = 1'b1; m_size[h] = 0; m_inuse++; e_data = h;
                end
            end
            1: begin
                if (!tgt) e_err = 1'b1;
                else begin
                    m_freed.push_back(arr); m_alloc[arr] = 1'b0; m_inuse--; e_known = 1'b0;
                end
            end
            2: begin
                if (!tgt) e_err = 1'b1;
                else begin
                    m_mem[arr][idx] = data; m_known[arr][idx] = 1'b1;
                    if (idx + 1 > m_size[arr]) m_size[arr] = idx + 1;
                    e_data = data;
                end
            end
            3: begin
                if (!tgt) e_err = 1'b1;
                else begin e_data = m_mem[arr][idx]; e_known = m_known[arr][idx]; end
            end
            4: begin
                if (!tgt) e_err = 1'b1;
                else e_data = m_size[arr];
            end
`ifdef ARRAY_INSERT_EN
            5: begin
                if (!tgt || m_size[arr] >= NAREA || idx > m_size[arr]) e_err = 1'b1;
                else begin
                    e_lat = m_size[arr] - idx + 2;
                    for (int j = m_size[arr]; j > idx; j--) begin
                        m_mem[arr][j]   = m_mem[arr][j-1];
                        m_known[arr][j] = m_known[arr][j-1];
                    end
                    m_mem[arr][idx] = data; m_known[arr][idx] = 1'b1;
                    m_size[arr]++;
                    e_data = data;
                end
            end
`endif
            default: e_err = 1'b1;
        endcase
        if (e_err) begin e_data = 0; e_known = 1'b1; end
    endfunction

    task automatic do_cmd(input int op, input int arr, input int idx, input int data);
        bit e_err, e_known;
        int e_data, e_lat, w;
        model_exec(op, arr, idx, data, e_err, e_data, e_known, e_lat);
        @(negedge clock);
        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin @(negedge clock); w++; end
        check("ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op[2:0];
        cmd_array = arr[AW-1:0];
        cmd_index = idx[IW-1:0];
        cmd_data  = data[WIDTH-1:0];
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        obs_lat = 1;
        while (rsp_valid !== 1'b1 && obs_lat < 40) begin
            check("busy_ready_low", cmd_ready, 0);
            @(posedge clock); #1;
            obs_lat++;
        end
        check("rsp_valid", rsp_valid, 1);
        check("latency", obs_lat, e_lat);
        check("rsp_ready_low", cmd_ready, 0);
        check("rsp_error", rsp_error, e_err);
        if (e_known) check("rsp_data", rsp_data, e_data);
        check("in_use", in_use, m_inuse);
        obs_data = rsp_data;
        obs_err  = rsp_error;
        @(posedge clock); #1;
        check("pulse_end", {rsp_valid, rsp_error, rsp_data}, 0);
        check("ready_back", cmd_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, cmd_ready, 1);
        check({tag, "_valid"}, rsp_valid, 0);
        check({tag, "_data"}, rsp_data, 0);
        check({tag, "_error"}, rsp_error, 0);
        check({tag, "_in_use"}, in_use, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst");
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int r, op, arr, idx, data, k;
        bit found;
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0;
        cmd_array = '0; cmd_index = '0; cmd_data = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("por");
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 3; i++) begin
            do_cmd(0, 0, 0, 0);
            check("alloc_seq", obs_data, i);
        end
        check("in_use3", in_use, 3);

        do_cmd(1, 1, 0, 0);
        do_cmd(1, 2, 0, 0);
        do_cmd(0, 0, 0, 0); check("lifo_first", obs_data, 2);
        do_cmd(0, 0, 0, 0); check("lifo_second", obs_data, 1);
        do_cmd(1, 1, 0, 0); check("free_ok", obs_err, 0);
        do_cmd(1, 1, 0, 0); check("double_free", obs_err, 1);
        check("double_free_in_use", in_use, 2);

        do_cmd(2, 0, 2, 3);
        do_cmd(4, 0, 0, 0); check("size_after_w2", obs_data, 3);
        do_cmd(2, 0, 0, 0);
        do_cmd(4, 0, 0, 0); check("size_after_w0", obs_data, 3);
        do_cmd(3, 0, 2, 0); check("read_idx2", obs_data, 3);

        for (int n = 0; n < 250; n++) begin
            r  = $urandom_range(0, 99);
            op = (r < 14) ? 0 : (r < 24) ? 1 : (r < 50) ? 2 : (r < 70) ? 3 :
                 (r < 80) ? 4 : (r < 93) ? 5 : (r < 97) ? 6 : 7;
            arr = $urandom_range(0, NARRAYS - 1);
            if ($urandom_range(0, 3) != 0) begin
                found = 1'b0;
                for (int j = 0; j < NARRAYS; j++) begin
                    k = (arr + j) % NARRAYS;
                    if (!found && m_alloc[k]) begin arr = k; found = 1'b1; end
                end
            end
            idx = $urandom_range(0, NAREA);
            if (op == 5 && $urandom_range(0, 1) == 1) idx = $urandom_range(0, m_size[arr]);
            data = $urandom_range(0, (1 << WIDTH) - 1);
            do_cmd(op, arr, idx, data);
        end

        do_reset();
        for (int i = 0; i < NARRAYS; i++) begin
            do_cmd(0, 0, 0, 0);
            check("exhaust_handle", obs_data, i);
        end
        do_cmd(0, 0, 0, 0);
        check("exhaust_err", obs_err, 1);
        check("exhaust_data", obs_data, 0);
        check("exhaust_in_use", in_use, NARRAYS);
        do_cmd(2, 3, NAREA, 7);
        check("write_idx_narea", obs_err, 1);

        do_reset();
        do_cmd(0, 0, 0, 0);
        do_cmd(2, 0, 0, 5);
        do_cmd(2, 0, 1, 6);
        do_cmd(2, 0, 2, 7);
        do_cmd(5, 0, 1, 9);
`ifdef ARRAY_INSERT_EN
        check("insert_err", obs_err, 0);
        check("insert_latency", obs_lat, 4);
        do_cmd(3, 0, 0, 0); check("ins_e0", obs_data, 5);
        do_cmd(3, 0, 1, 0); check("ins_e1", obs_data, 9);
        do_cmd(3, 0, 2, 0); check("ins_e2", obs_data, 6);
        do_cmd(3, 0, 3, 0); check("ins_e3", obs_data, 7);
        do_cmd(4, 0, 0, 0); check("ins_size", obs_data, 4);
`else
        check("insert_disabled_err", obs_err, 1);
        do_cmd(4, 0, 0, 0); check("noins_size", obs_data, 3);
        do_cmd(3, 0, 1, 0); check("noins_e1", obs_data, 6);
`endif

        // Reset while a long command is in flight
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_array = '0; cmd_index = '0; cmd_data = 12'd1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
`ifdef ARRAY_INSERT_EN
        check("shift_busy", {cmd_ready, rsp_valid}, 0);
        @(posedge clock); #1;
`endif
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid");
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        do_cmd(0, 0, 0, 0);
        check("alloc_after_reset", obs_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
